// File: rtl/instr_fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, issues ROM/switch words as one-cycle valid pulses,
// with IDLE/RUN/HALTED control. Optional run-mode breakpoint enabled by FETCH_BREAKPOINT_EN.
module instr_fetch_sequencer #(
  parameter int                   ADDR_W   = 5,
  parameter int                   INSTR_W  = 16,
  parameter int                   TICK_DIV = 100000000,
  parameter logic [INSTR_W-1:0]   NOP_WORD = 16'h8000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               step,
  input  logic               sw_load,
  input  logic               run_toggle,
  input  logic [INSTR_W-1:0] sw_ins,
  input  logic [INSTR_W-1:0] rom_data,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               halt,
`ifdef FETCH_BREAKPOINT_EN
  input  logic               bp_en,
  input  logic [ADDR_W-1:0]  bp_addr,
  output logic               bp_hit,
`endif
  output logic [ADDR_W-1:0]  rom_addr,
  output logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic               run_active,
  output logic               halted
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  localparam int                TICK_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic [1:0]         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               instr_valid_q, instr_valid_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic               rom_issue, sw_issue, terminal, bp_trip;

`ifdef FETCH_BREAKPOINT_EN
  logic bp_hit_q, bp_hit_d;
  assign bp_trip = bp_en && (pc_q == bp_addr);
  assign bp_hit  = bp_hit_q;
`else
  assign bp_trip = 1'b0;
`endif

  assign terminal = (tick_q == TICK_LAST);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = NOP_WORD;
    instr_valid_d = 1'b0;
    tick_d        = tick_q;
    rom_issue     = 1'b0;
    sw_issue      = 1'b0;
`ifdef FETCH_BREAKPOINT_EN
    bp_hit_d      = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        tick_d = '0;
        if (run_toggle) begin
          state_d = S_RUN;
        end else if (!instr_valid_q) begin
          if (step)         rom_issue = 1'b1;
          else if (sw_load) sw_issue  = 1'b1;
        end
      end
      S_RUN: begin
        if (run_toggle) begin
          state_d = S_IDLE;
          tick_d  = '0;
        end else if (terminal) begin
          tick_d = '0;
          if (bp_trip) begin
            state_d = S_IDLE;
`ifdef FETCH_BREAKPOINT_EN
            bp_hit_d = 1'b1;
`endif
          end else if (!instr_valid_q) begin
            rom_issue = 1'b1;
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      S_HALTED: tick_d = '0;
      default: begin
        state_d = S_IDLE;
        tick_d  = '0;
      end
    endcase

    if (rom_issue) begin
      instr_d       = rom_data;
      instr_valid_d = 1'b1;
      pc_d          = pc_q + ADDR_W'(1);
    end
    if (sw_issue) begin
      instr_d       = sw_ins;
      instr_valid_d = 1'b1;
    end

    // Branch/halt qualify the word currently on instr; a branch beats any increment.
    if (instr_valid_q) begin
      if (branch_taken) pc_d = branch_target;
      if (halt) begin
        state_d = S_HALTED;
        tick_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      instr_q       <= NOP_WORD;
      instr_valid_q <= 1'b0;
      tick_q        <= '0;
`ifdef FETCH_BREAKPOINT_EN
      bp_hit_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      tick_q        <= tick_d;
`ifdef FETCH_BREAKPOINT_EN
      bp_hit_q      <= bp_hit_d;
`endif
    end
  end

  assign rom_addr    = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign run_active  = (state_q == S_RUN);
  assign halted      = (state_q == S_HALTED);

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Bench for instr_fetch_sequencer: directed vector table, breakpoint sequence (when enabled),
// then randomized stimulus against an event-level reference model.
module tb_instr_fetch_sequencer;
  localparam int          TD  = 4;
  localparam logic [15:0] NOP = 16'h8000;

  logic        clk = 1'b0;
  logic        reset, step, sw_load, run_toggle, branch_taken, halt;
  logic [15:0] sw_ins, rom_data, instr;
  logic [4:0]  branch_target, rom_addr, pc;
  logic        instr_valid, run_active, halted;
`ifdef FETCH_BREAKPOINT_EN
  logic        bp_en, bp_hit;
  logic [4:0]  bp_addr;
`endif

  logic [15:0] rom [32];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;
  assign rom_data = rom[rom_addr];

  instr_fetch_sequencer #(
    .ADDR_W(5), .INSTR_W(16), .TICK_DIV(TD), .NOP_WORD(NOP)
  ) dut (
    .clk(clk), .reset(reset), .step(step), .sw_load(sw_load), .run_toggle(run_toggle),
    .sw_ins(sw_ins), .rom_data(rom_data), .branch_taken(branch_taken),
    .branch_target(branch_target), .halt(halt),
`ifdef FETCH_BREAKPOINT_EN
    .bp_en(bp_en), .bp_addr(bp_addr), .bp_hit(bp_hit),
`endif
    .rom_addr(rom_addr), .pc(pc), .instr(instr), .instr_valid(instr_valid),
    .run_active(run_active), .halted(halted)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [4:0] e_pc, input logic [15:0] e_instr,
                         input logic e_v, input logic e_run, input logic e_halt);
    chk({tag, "/pc"}, 32'(pc), 32'(e_pc));
    chk({tag, "/rom_addr"}, 32'(rom_addr), 32'(e_pc));
    chk({tag, "/instr"}, 32'(instr), 32'(e_instr));
    chk({tag, "/instr_valid"}, 32'(instr_valid), 32'(e_v));
    chk({tag, "/run_active"}, 32'(run_active), 32'(e_run));
    chk({tag, "/halted"}, 32'(halted), 32'(e_halt));
  endtask

  task automatic clear_inputs();
    reset = 0; step = 0; sw_load = 0; run_toggle = 0; branch_taken = 0; halt = 0;
    branch_target = '0; sw_ins = '0;
`ifdef FETCH_BREAKPOINT_EN
    bp_en = 0; bp_addr = '0;
`endif
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic rst, stp, swl, rtg, br, hlt;
    logic [4:0] tgt;
    logic [15:0] sw;
    logic [4:0] e_pc;
    logic [15:0] e_instr;
    logic e_v, e_run, e_halt;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t v(input logic rst, stp, swl, rtg, br, input logic [4:0] tgt,
                             input logic hlt, input logic [15:0] sw, input logic [4:0] epc,
                             input logic [15:0] ei, input logic ev, er, eh);
    vec_t r;
    r.rst = rst; r.stp = stp; r.swl = swl; r.rtg = rtg; r.br = br; r.tgt = tgt; r.hlt = hlt;
    r.sw = sw; r.e_pc = epc; r.e_instr = ei; r.e_v = ev; r.e_run = er; r.e_halt = eh;
    return r;
  endfunction

  // Reference model: event rules applied once per clock edge.
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;
  int          m_mode, m_cyc;
  logic [4:0]  m_pc;
  logic [15:0] m_instr;
  logic        m_v, m_bp;

  task automatic model_edge();
    logic [4:0]  n_pc;
    logic [15:0] n_instr;
    logic        n_v;
    int          n_mode;
    logic        do_rom, do_sw, brk;
    if (reset) begin
      m_mode = M_IDLE; m_cyc = 0; m_pc = 0; m_instr = NOP; m_v = 0; m_bp = 0;
      return;
    end
    n_pc = m_pc; n_instr = NOP; n_v = 0; n_mode = m_mode;
    do_rom = 0; do_sw = 0; brk = 0;
    if (m_mode == M_IDLE) begin
      if (run_toggle) begin n_mode = M_RUN; m_cyc = 0; end
      else if (!m_v && step) do_rom = 1;
      else if (!m_v && sw_load) do_sw = 1;
    end else if (m_mode == M_RUN) begin
      if (run_toggle) n_mode = M_IDLE;
      else begin
        m_cyc++;
        if (m_cyc % TD == 0) begin
`ifdef FETCH_BREAKPOINT_EN
          brk = bp_en && (m_pc == bp_addr);
`endif
          if (brk) n_mode = M_IDLE;
          else if (!m_v) do_rom = 1;
        end
      end
    end
    if (do_rom) begin n_instr = rom[m_pc]; n_v = 1; n_pc = m_pc + 5'd1; end
    if (do_sw)  begin n_instr = sw_ins; n_v = 1; end
    if (m_v && branch_taken) n_pc = branch_target;
    if (m_v && halt) n_mode = M_HALT;
    m_pc = n_pc; m_instr = n_instr; m_v = n_v; m_mode = n_mode; m_bp = brk;
  endtask

  initial begin
    clear_inputs();
    for (int i = 0; i < 32; i++) rom[i] = 16'h3000 | 16'(i);
    rom[0] = 16'h2103;

    //        rst stp swl rtg br tgt    hlt sw        pc     instr     v  run hlt
    vecs.push_back(v(1, 0, 0, 0, 0, 5'd0,  0, 16'h0,    5'd0,  NOP,      0, 0, 0));
    vecs.push_back(v(1, 1, 1, 1, 0, 5'd0,  0, 16'h0,    5'd0,  NOP,      0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0, 0, 5'd0,  0, 16'h0,    5'd1,  16'h2103, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 5'd0,  0, 16'h0,    5'd1,  NOP,      0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0, 0, 5'd0,  0, 16'h0,    5'd2,  16'h3001, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 5'd0,  0, 16'h0,    5'd2,  NOP,      0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0, 0, 5'd0,  0, 16'h0,    5'd3,  16'h3002, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 5'd0,  0, 16'h0,    5'd3,  NOP,      0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0, 0, 5'd0,  0, 16'h0,    5'd4,  16'h3003, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 5'd17, 0, 16'h0,    5'd17, NOP,      0, 0, 0));
    vecs.push_back(v(0, 1, 1, 0, 0, 5'd0,  0, 16'h4A55, 5'd18, 16'h3011, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 5'd0,  0, 16'h4A55, 5'd18, NOP,      0, 0, 0));
    vecs.push_back(v(0, 0, 1, 0, 0, 5'd0,  0, 16'h4A55, 5'd18, 16'h4A55, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 5'd0,  0, 16'h0,    5'd18, NOP,      0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0, 0, 5'd0,  0, 16'h0,    5'd19, 16'h3012, 1, 0, 0));
    vecs.push_back(v(0, 1, 0, 0, 0, 5'd0,  0, 16'h0,    5'd19, NOP,      0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0, 0, 5'd0,  0, 16'h0,    5'd20, 16'h3013, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 5'd31, 0, 16'h0,    5'd31, NOP,      0, 0, 0));
    vecs.push_back(v(0, 1, 0, 0, 0, 5'd0,  0, 16'h0,    5'd0,  16'h301F, 1, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 5'd0,  0, 16'h0,    5'd0,  NOP,      0, 0, 0));
    vecs.push_back(v(0, 0, 0, 1, 0, 5'd0,  0, 16'h0,    5'd0,  NOP,      0, 1, 0));
    vecs.push_back(v(0, 1, 0, 0, 0, 5'd0,  0, 16'h0,    5'd0,  NOP,      0, 1, 0));
    vecs.push_back(v(0, 0, 1, 0, 0, 5'd0,  0, 16'h0,    5'd0,  NOP,      0, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 5'd0,  0, 16'h0,    5'd0,  NOP,      0, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 5'd0,  0, 16'h0,    5'd1,  16'h2103, 1, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 5'd0,  0, 16'h0,    5'd1,  NOP,      0, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 5'd0,  0, 16'h0,    5'd1,  NOP,      0, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 5'd0,  0, 16'h0,    5'd1,  NOP,      0, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 5'd0,  0, 16'h0,    5'd2,  16'h3001, 1, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 5'd0,  0, 16'h0,    5'd2,  NOP,      0, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 5'd0,  0, 16'h0,    5'd2,  NOP,      0, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 5'd0,  0, 16'h0,    5'd2,  NOP,      0, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 5'd0,  0, 16'h0,    5'd3,  16'h3002, 1, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 5'd0,  1, 16'h0,    5'd3,  NOP,      0, 0, 1));
    vecs.push_back(v(0, 1, 0, 0, 0, 5'd0,  0, 16'h0,    5'd3,  NOP,      0, 0, 1));
    vecs.push_back(v(0, 0, 0, 1, 0, 5'd0,  0, 16'h0,    5'd3,  NOP,      0, 0, 1));
    vecs.push_back(v(0, 0, 1, 0, 0, 5'd0,  0, 16'h1234, 5'd3,  NOP,      0, 0, 1));
    vecs.push_back(v(0, 0, 0, 0, 0, 5'd0,  0, 16'h0,    5'd3,  NOP,      0, 0, 1));
    vecs.push_back(v(1, 1, 0, 0, 0, 5'd0,  0, 16'h0,    5'd0,  NOP,      0, 0, 0));

    #1;
    foreach (vecs[i]) begin
      reset = vecs[i].rst; step = vecs[i].stp; sw_load = vecs[i].swl;
      run_toggle = vecs[i].rtg; branch_taken = vecs[i].br; branch_target = vecs[i].tgt;
      halt = vecs[i].hlt; sw_ins = vecs[i].sw;
      cyc();
      chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_v,
              vecs[i].e_run, vecs[i].e_halt);
    end

`ifdef FETCH_BREAKPOINT_EN
    clear_inputs();
    reset = 1; cyc();
    chk("bp/reset_hit", 32'(bp_hit), 32'd0);
    reset = 0; bp_en = 1; bp_addr = 5'd2; run_toggle = 1; cyc();
    run_toggle = 0;
    chk_all("bp/enter", 5'd0, NOP, 0, 1, 0);
    for (int c = 1; c <= 12; c++) begin
      cyc();
      if (c == 4)       chk_all($sformatf("bp/c%0d", c), 5'd1, rom[0], 1, 1, 0);
      else if (c == 8)  chk_all($sformatf("bp/c%0d", c), 5'd2, rom[1], 1, 1, 0);
      else if (c == 12) chk_all($sformatf("bp/c%0d", c), 5'd2, NOP, 0, 0, 0);
      else              chk($sformatf("bp/c%0d_valid", c), 32'(instr_valid), 32'd0);
      chk($sformatf("bp/c%0d_hit", c), 32'(bp_hit), (c == 12) ? 32'd1 : 32'd0);
    end
    cyc();
    chk("bp/hit_drop", 32'(bp_hit), 32'd0);
    step = 1; cyc(); step = 0;
    chk_all("bp/step", 5'd3, rom[2], 1, 0, 0);
    chk("bp/step_hit", 32'(bp_hit), 32'd0);
`endif

    for (int i = 0; i < 32; i++) rom[i] = 16'($urandom);
    for (int n = 0; n < 4000; n++) begin
      reset         = (n == 0) || ($urandom_range(0, 99) == 0);
      step          = ($urandom_range(0, 2) == 0);
      sw_load       = ($urandom_range(0, 2) == 0);
      run_toggle    = ($urandom_range(0, 19) == 0);
      branch_taken  = ($urandom_range(0, 2) == 0);
      branch_target = 5'($urandom);
      halt          = ($urandom_range(0, 24) == 0);
      sw_ins        = 16'($urandom);
`ifdef FETCH_BREAKPOINT_EN
      bp_en         = ($urandom_range(0, 1) == 0);
      bp_addr       = 5'($urandom_range(0, 7));
`endif
      model_edge();
      cyc();
      chk_all($sformatf("rnd%0d", n), m_pc, m_instr, m_v, m_mode == M_RUN, m_mode == M_HALT);
`ifdef FETCH_BREAKPOINT_EN
      chk($sformatf("rnd%0d/bp_hit", n), 32'(bp_hit), 32'(m_bp));
`endif
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/instr_fetch_sequencer.md
Name: instr_fetch_sequencer

Overview:
- Front-end stage feeding the processor's instruction register and control path.
- Owns the program counter and drives the instruction ROM address.
- Accepts debounced single-cycle button pulses, issues one instruction per event as a one-cycle valid word, and idles on NOP otherwise.
- Adds a free-running RUN mode, branch redirect and halt-on-stop.

Parameters:
- ADDR_W, 5, ROM address / PC width (32 words).
- INSTR_W, 16, instruction width.
- TICK_DIV, 100000000, RUN-mode issue period in clk cycles; must be >= 2.
- NOP_WORD, 16'h8000, word driven on instr when nothing is issued.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- step  in  1  debounced one-cycle pulse: fetch ROM[pc] and issue it.
- sw_load  in  1  debounced one-cycle pulse: issue sw_ins.
- run_toggle  in  1  debounced one-cycle pulse: toggle IDLE/RUN.
- sw_ins  in  INSTR_W  switch instruction word.
- rom_data  in  INSTR_W  ROM read data (combinational from rom_addr).
- branch_taken  in  1  from the branch mux; valid while instr_valid=1.
- branch_target  in  ADDR_W  branch destination (instr[12:8] of the issued word).
- halt  in  1  decoded stop; valid while instr_valid=1.
- rom_addr  out  ADDR_W  equals pc (combinational).
- pc  out  ADDR_W  program counter.
- instr  out  INSTR_W  issued instruction, registered.
- instr_valid  out  1  one-cycle pulse on issue.
- run_active  out  1  high in RUN.
- halted  out  1  high in HALTED.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high, named reset.
- Reset values: state=IDLE, pc=0, instr=NOP_WORD, instr_valid=0, run_active=0, halted=0, tick counter=0. Reset wins over every other input in the same cycle.
- States: IDLE, RUN, HALTED.
- Issue gate: an issue is allowed only when instr_valid=0, so issues are at least 2 cycles apart. An event arriving while instr_valid=1 is dropped.
- ROM issue (rising edge E):
  - instr <= rom_data; instr_valid <= 1; pc <= pc+1.
  - pc wraps 2^ADDR_W-1 -> 0.
- Switch issue:
  - instr <= sw_ins; instr_valid <= 1; pc unchanged.
- Non-issue cycles: instr <= NOP_WORD, instr_valid <= 0.
- Branch:
  - Sampled in the cycle where instr_valid=1. If branch_taken=1, pc <= branch_target at the next edge, overriding the earlier increment.
  - Applies to switch-issued words too.
- Halt:
  - If halt=1 in a valid cycle, next state is HALTED. Branch in that same cycle still updates pc.
  - HALTED ignores step, sw_load and run_toggle; only reset exits.
- IDLE:
  - Priority run_toggle > step > sw_load; lower-priority pulses in the same cycle are dropped.
  - run_toggle: enter RUN, tick counter <= 0.
- RUN:
  - Tick counter counts 0..TICK_DIV-1. At terminal count it performs a ROM issue (subject to the issue gate) and wraps to 0.
  - First issue occurs TICK_DIV cycles after entering RUN.
  - step and sw_load are ignored.
  - run_toggle: return to IDLE with the counter cleared; a terminal count in the same cycle is dropped.
- run_active=1 iff state=RUN; halted=1 iff state=HALTED.

Optional Feature:
- Macro: FETCH_BREAKPOINT_EN.
- When defined, adds:
  - bp_en  in  1
  - bp_addr  in  ADDR_W
  - bp_hit  out  1  (reset value 0)
- With the macro, in RUN, at terminal count with bp_en=1 and pc==bp_addr:
  - no issue;
  - state <= IDLE;
  - bp_hit pulses 1 cycle.
  - A following step issues ROM[bp_addr] normally; step never triggers the breakpoint.
- Without the macro, these ports and this logic are absent; RUN never stops on its own.

Test Plan:
- Assert reset 2 cycles -> pc=0, rom_addr=0, instr=16'h8000, instr_valid=0, run_active=0, halted=0.
- rom[0]=16'h2103, pulse step -> next cycle: instr=16'h2103, instr_valid=1, pc=1; the cycle after: instr=16'h8000, instr_valid=0.
- pc=3, step, hold branch_taken=1 and branch_target=5'd17 during the valid cycle -> pc=17 one cycle later. pc=31, step, no branch -> pc=0.
- step and sw_load in the same cycle with sw_ins=16'h4A55 -> ROM word issued, pc+1, 16'h4A55 never appears. Then sw_load alone -> instr=16'h4A55, pc unchanged.
- TICK_DIV=4, run_toggle -> issues exactly every 4 cycles with pc 0,1,2. At the 3rd issue assert halt -> halted=1, run_active=0; later step/run_toggle give no issue; reset -> IDLE, pc=0.
- FETCH_BREAKPOINT_EN, TICK_DIV=4, bp_en=1, bp_addr=2, run from pc=0 -> issues at pc 0 and 1, then bp_hit pulse and run_active=0 with pc=2. A step then issues ROM[2].
